// File: rtl/core_wbu_top.sv
`default_nettype none
// ============================================================================
//  Module      : core_wbu_top
//  Description : riscv32 write-back stage. Holds one executed instruction,
//                selects its result source, drives the GPR write port,
//                pulses a commit notification and counts retired
//                instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_wbu_top #(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 wbu_rx_valid,
    output logic                 wbu_rx_ready,
    input  logic [31:0]          wbu_rx_exu_res,
    input  logic [31:0]          wbu_rx_pc,
    input  logic [31:0]          wbu_rx_pc_seq,
    input  logic [31:0]          wbu_rx_imme,
    input  logic [31:0]          wbu_rx_csr_rdata,
    input  logic                 wbu_rx_imme_valid,
    input  logic                 wbu_rx_pc_valid,
    input  logic                 wbu_rx_pc_seq_valid,
    input  logic                 wbu_rx_csr_valid,
    input  logic                 wbu_rx_alu_valid,
    input  logic [4:0]           wbu_rx_rd_idx,

    output logic                 gpr_wr_en,
    input  logic                 gpr_wr_ready,
    output logic [4:0]           gpr_wr_idx,
    output logic [31:0]          gpr_wr_data,

    output logic                 wbu_commit,
    output logic [4:0]           wbu_commit_rd_idx,
    output logic [INSTRET_W-1:0] wbu_instret,
    output logic                 wbu_err_multi_sel
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WB   = 1'b1
    } state_t;

    localparam logic [INSTRET_W-1:0] C_INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_t                 r_state_q,      w_state_d;
    logic                   r_wr_req_q,     w_wr_req_d;
    logic [4:0]             r_rd_q,         w_rd_d;
    logic [31:0]            r_data_q,       w_data_d;
    logic                   r_commit_q,     w_commit_d;
    logic [4:0]             r_commit_rd_q,  w_commit_rd_d;
    logic [INSTRET_W-1:0]   r_instret_q,    w_instret_d;
    logic                   r_err_q,        w_err_d;

    logic [4:0]             w_sel;
    logic                   w_sel_any;
    logic                   w_sel_multi;
    logic [31:0]            w_mux_data;
    logic                   w_done;
    logic                   w_rx_ena;

    // Handshake: the held instruction retires when it needs no write or the GPR file takes it
    always_comb begin
        w_done       = (r_state_q == S_WB) && (!r_wr_req_q || gpr_wr_ready);
        wbu_rx_ready = (r_state_q == S_IDLE) || w_done;
        w_rx_ena     = wbu_rx_valid && wbu_rx_ready;
    end

    // Result source select, fixed priority alu > csr > pc_seq > pc > imme
    always_comb begin
        w_sel       = {wbu_rx_alu_valid, wbu_rx_csr_valid, wbu_rx_pc_seq_valid,
                       wbu_rx_pc_valid, wbu_rx_imme_valid};
        w_sel_any   = |w_sel;
        // More than one bit set iff clearing the lowest set bit leaves something
        w_sel_multi = |(w_sel & (w_sel - 5'd1));
        w_mux_data  = 32'd0;
        if (wbu_rx_alu_valid)         w_mux_data = wbu_rx_exu_res;
        else if (wbu_rx_csr_valid)    w_mux_data = wbu_rx_csr_rdata;
        else if (wbu_rx_pc_seq_valid) w_mux_data = wbu_rx_pc_seq;
        else if (wbu_rx_pc_valid)     w_mux_data = wbu_rx_pc;
        else if (wbu_rx_imme_valid)   w_mux_data = wbu_rx_imme;
    end

    // Next-state: retire the held instruction and/or load a new one in the same edge
    always_comb begin
        w_state_d     = r_state_q;
        w_wr_req_d    = r_wr_req_q;
        w_rd_d        = r_rd_q;
        w_data_d      = r_data_q;
        w_commit_d    = w_done;
        w_commit_rd_d = (w_done && r_wr_req_q) ? r_rd_q : 5'd0;
        w_instret_d   = w_done ? (r_instret_q + C_INSTRET_ONE) : r_instret_q;
        w_err_d       = r_err_q || (w_rx_ena && w_sel_multi);

        if (w_rx_ena) begin
            w_rd_d     = wbu_rx_rd_idx;
            w_data_d   = w_mux_data;
            // x0 writes are swallowed here so they never reach the GPR port
            w_wr_req_d = w_sel_any && (wbu_rx_rd_idx != 5'd0);
        end

        case (r_state_q)
            S_IDLE:  if (w_rx_ena) w_state_d = S_WB;
            S_WB:    if (w_done)   w_state_d = w_rx_ena ? S_WB : S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any held instruction without commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_wr_req_q    <= 1'b0;
            r_rd_q        <= 5'd0;
            r_data_q      <= 32'd0;
            r_commit_q    <= 1'b0;
            r_commit_rd_q <= 5'd0;
            r_instret_q   <= '0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_wr_req_q    <= w_wr_req_d;
            r_rd_q        <= w_rd_d;
            r_data_q      <= w_data_d;
            r_commit_q    <= w_commit_d;
            r_commit_rd_q <= w_commit_rd_d;
            r_instret_q   <= w_instret_d;
            r_err_q       <= w_err_d;
        end
    end

    assign gpr_wr_en         = (r_state_q == S_WB) && r_wr_req_q;
    assign gpr_wr_idx        = r_rd_q;
    assign gpr_wr_data       = r_data_q;
    assign wbu_commit        = r_commit_q;
    assign wbu_commit_rd_idx = r_commit_rd_q;
    assign wbu_instret       = r_instret_q;
    assign wbu_err_multi_sel = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_wbu_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_wbu_top
//  Description : Table-driven self-checking bench for core_wbu_top. A second
//                instance with a 2-bit retire counter exercises wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_wbu_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid, rx_ready, rx_ready2;
    logic [31:0] exu, pc, pcseq, imme, csr;
    logic        imme_v, pc_v, pcseq_v, csr_v, alu_v;
    logic [4:0]  rd;
    logic        wr_en, wr_en2, gready;
    logic [4:0]  wr_idx, wr_idx2, crd, crd2;
    logic [31:0] wr_data, wr_data2;
    logic        commit, commit2, err, err2;
    logic [63:0] instret;
    logic [1:0]  instret2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_wbu_top #(.INSTRET_W(64)) dut (
        .clk(clk), .rst(rst),
        .wbu_rx_valid(rx_valid), .wbu_rx_ready(rx_ready),
        .wbu_rx_exu_res(exu), .wbu_rx_pc(pc), .wbu_rx_pc_seq(pcseq),
        .wbu_rx_imme(imme), .wbu_rx_csr_rdata(csr),
        .wbu_rx_imme_valid(imme_v), .wbu_rx_pc_valid(pc_v),
        .wbu_rx_pc_seq_valid(pcseq_v), .wbu_rx_csr_valid(csr_v),
        .wbu_rx_alu_valid(alu_v), .wbu_rx_rd_idx(rd),
        .gpr_wr_en(wr_en), .gpr_wr_ready(gready), .gpr_wr_idx(wr_idx),
        .gpr_wr_data(wr_data), .wbu_commit(commit), .wbu_commit_rd_idx(crd),
        .wbu_instret(instret), .wbu_err_multi_sel(err)
    );

    core_wbu_top #(.INSTRET_W(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .wbu_rx_valid(rx_valid), .wbu_rx_ready(rx_ready2),
        .wbu_rx_exu_res(exu), .wbu_rx_pc(pc), .wbu_rx_pc_seq(pcseq),
        .wbu_rx_imme(imme), .wbu_rx_csr_rdata(csr),
        .wbu_rx_imme_valid(imme_v), .wbu_rx_pc_valid(pc_v),
        .wbu_rx_pc_seq_valid(pcseq_v), .wbu_rx_csr_valid(csr_v),
        .wbu_rx_alu_valid(alu_v), .wbu_rx_rd_idx(rd),
        .gpr_wr_en(wr_en2), .gpr_wr_ready(gready), .gpr_wr_idx(wr_idx2),
        .gpr_wr_data(wr_data2), .wbu_commit(commit2), .wbu_commit_rd_idx(crd2),
        .wbu_instret(instret2), .wbu_err_multi_sel(err2)
    );

    // sel bits: [4]=alu [3]=csr [2]=pc_seq [1]=pc [0]=imme
    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  sel;
        logic [4:0]  rd;
        logic [31:0] exu, pc, pcseq, imme, csr;
        logic        gready;
        logic        e_ready, e_en, chk_wr;
        logic [4:0]  e_idx;
        logic [31:0] e_data;
        logic        e_commit;
        logic [4:0]  e_crd;
        logic [31:0] e_instret;
        logic        e_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vec [NV];

    // Distractor values on the unselected sources so a wrong mux leg shows up
    localparam logic [31:0] XE = 32'hE0E0, XP = 32'hC0C0, XS = 32'hB0B0,
                            XI = 32'hA0A0, XC = 32'h9090;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst      = v.rst;
        rx_valid = v.valid;
        {alu_v, csr_v, pcseq_v, pc_v, imme_v} = v.sel;
        rd    = v.rd;
        exu   = v.exu;
        pc    = v.pc;
        pcseq = v.pcseq;
        imme  = v.imme;
        csr   = v.csr;
        gready = v.gready;
    endtask

    initial begin
        //        rst valid sel      rd    exu           pc      pcseq   imme          csr     gr   rdy en chk idx   data          cm crd   inst err
        vec[0]  = '{0, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     1,   1, 0, 1, 5'd0, 32'h0,        0, 5'd0, 0, 0};
        vec[1]  = '{0, 1, 5'b10000, 5'd5, 32'h1234,    XP,     XS,     XI,           XC,     1,   1, 0, 0, 5'd0, 32'h0,        0, 5'd0, 0, 0};
        vec[2]  = '{0, 1, 5'b00001, 5'd1, XE,          XP,     XS,     32'hABCDE000, XC,     1,   1, 1, 1, 5'd5, 32'h1234,     0, 5'd0, 0, 0};
        vec[3]  = '{0, 1, 5'b00100, 5'd2, XE,          XP,     32'h104, XI,          XC,     1,   1, 1, 1, 5'd1, 32'hABCDE000, 1, 5'd5, 1, 0};
        vec[4]  = '{0, 1, 5'b00010, 5'd3, XE,          32'h200, XS,    XI,           XC,     1,   1, 1, 1, 5'd2, 32'h104,      1, 5'd1, 2, 0};
        vec[5]  = '{0, 1, 5'b01000, 5'd4, XE,          XP,     XS,     XI,           32'h55, 1,   1, 1, 1, 5'd3, 32'h200,      1, 5'd2, 3, 0};
        vec[6]  = '{0, 1, 5'b10000, 5'd7, 32'h77,      XP,     XS,     XI,           XC,     0,   0, 1, 1, 5'd4, 32'h55,       1, 5'd3, 4, 0};
        vec[7]  = '{0, 1, 5'b10000, 5'd7, 32'h77,      XP,     XS,     XI,           XC,     0,   0, 1, 1, 5'd4, 32'h55,       0, 5'd0, 4, 0};
        vec[8]  = '{0, 1, 5'b10000, 5'd7, 32'h77,      XP,     XS,     XI,           XC,     0,   0, 1, 1, 5'd4, 32'h55,       0, 5'd0, 4, 0};
        vec[9]  = '{0, 1, 5'b10000, 5'd7, 32'h77,      XP,     XS,     XI,           XC,     1,   1, 1, 1, 5'd4, 32'h55,       0, 5'd0, 4, 0};
        vec[10] = '{0, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     1,   1, 1, 1, 5'd7, 32'h77,       1, 5'd4, 5, 0};
        vec[11] = '{0, 1, 5'b10000, 5'd0, 32'h99,      XP,     XS,     XI,           XC,     1,   1, 0, 0, 5'd0, 32'h0,        1, 5'd7, 6, 0};
        vec[12] = '{0, 1, 5'b00000, 5'd9, XE,          XP,     XS,     XI,           XC,     1,   1, 0, 0, 5'd0, 32'h0,        0, 5'd0, 6, 0};
        vec[13] = '{0, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     1,   1, 0, 0, 5'd0, 32'h0,        1, 5'd0, 7, 0};
        vec[14] = '{0, 1, 5'b11000, 5'd6, 32'h11,      XP,     XS,     XI,           32'h22, 1,   1, 0, 0, 5'd0, 32'h0,        1, 5'd0, 8, 0};
        vec[15] = '{0, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     1,   1, 1, 1, 5'd6, 32'h11,       0, 5'd0, 8, 1};
        vec[16] = '{0, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     1,   1, 0, 0, 5'd0, 32'h0,        1, 5'd6, 9, 1};
        vec[17] = '{0, 1, 5'b10000, 5'd8, 32'h88,      XP,     XS,     XI,           XC,     0,   1, 0, 0, 5'd0, 32'h0,        0, 5'd0, 9, 1};
        vec[18] = '{0, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     0,   0, 1, 1, 5'd8, 32'h88,       0, 5'd0, 9, 1};
        vec[19] = '{1, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     0,   0, 1, 1, 5'd8, 32'h88,       0, 5'd0, 9, 1};
        vec[20] = '{0, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     1,   1, 0, 1, 5'd0, 32'h0,        0, 5'd0, 0, 0};
        vec[21] = '{0, 0, 5'b00000, 5'd0, XE,          XP,     XS,     XI,           XC,     1,   1, 0, 0, 5'd0, 32'h0,        0, 5'd0, 0, 0};

        drive(vec[0]);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Each row: drive after the edge, sample mid-cycle, then advance one edge
        for (int i = 0; i < NV; i++) begin
            drive(vec[i]);
            #4;
            chk($sformatf("row%0d rx_ready", i),   64'(rx_ready),  64'(vec[i].e_ready));
            chk($sformatf("row%0d gpr_wr_en", i),  64'(wr_en),     64'(vec[i].e_en));
            if (vec[i].chk_wr) begin
                chk($sformatf("row%0d gpr_wr_idx", i),  64'(wr_idx),  64'(vec[i].e_idx));
                chk($sformatf("row%0d gpr_wr_data", i), 64'(wr_data), 64'(vec[i].e_data));
            end
            chk($sformatf("row%0d commit", i),     64'(commit),    64'(vec[i].e_commit));
            chk($sformatf("row%0d commit_rd", i),  64'(crd),       64'(vec[i].e_crd));
            chk($sformatf("row%0d instret", i),    instret,        64'(vec[i].e_instret));
            chk($sformatf("row%0d instret_w2", i), 64'(instret2),  64'(vec[i].e_instret[1:0]));
            chk($sformatf("row%0d err_multi", i),  64'(err),       64'(vec[i].e_err));
            @(posedge clk);
            #1;
        end

        // Single instruction after reset: commit must arrive within a bounded window
        begin
            vec_t v;
            bit   seen;
            v = vec[21];
            v.valid = 1'b1;
            v.sel   = 5'b10000;
            v.rd    = 5'd10;
            v.exu   = 32'hAA;
            drive(v);
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            alu_v    = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 5 && !seen; c++) begin
                #4;
                if (commit) begin
                    seen = 1'b1;
                    chk("tail commit_rd", 64'(crd), 64'd10);
                    chk("tail instret", instret, 64'd1);
                end
                @(posedge clk);
                #1;
            end
            chk("tail commit_seen", 64'(seen), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
